// File: rtl/mab_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module : mab_sequencer_if
// Brief  : Request/source/MAB bundle between control unit, sequencer and memory.
// Rev    : 1.0  initial release
// =============================================================================
interface mab_sequencer_if #(
   parameter int AW    = 16,
   parameter int NSRC  = 5,
   parameter int SEL_W = 3
);
   logic                 req;
   logic [SEL_W-1:0]     sel;
   logic                 rw;
   logic                 bw;
   logic [NSRC*AW-1:0]   src_addr;
   logic                 calc_done;
   logic [AW-1:0]        mab_out;
   logic                 mab_valid;
   logic                 mab_rw;
   logic                 mab_bw;
   logic                 busy;
   logic                 mab_done;
   logic                 sel_err;
   logic                 align_err;
   logic                 timeout_err;

   modport master (
      output req, sel, rw, bw, src_addr, calc_done,
      input  mab_out, mab_valid, mab_rw, mab_bw, busy, mab_done,
             sel_err, align_err, timeout_err
   );

   modport slave (
      input  req, sel, rw, bw, src_addr, calc_done,
      output mab_out, mab_valid, mab_rw, mab_bw, busy, mab_done,
             sel_err, align_err, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/mab_sequencer.sv
`default_nettype none
// =============================================================================
// Module : mab_sequencer
// Brief  : Selects an address source on req, registers it onto the MAB with
//          wait states, bounded calc wait, word alignment and error flags.
// Rev    : 1.0  initial release
// =============================================================================
module mab_sequencer #(
   parameter int AW           = 16,
   parameter int NSRC         = 5,
   parameter int SEL_W        = 3,
   parameter int DEFAULT_SRC  = 0,
   parameter int CALC_SRC     = 2,
   parameter int WAIT_STATES  = 0,
   parameter int CALC_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   mab_sequencer_if.slave   bus
);
   localparam int CNT_MAX = (WAIT_STATES > CALC_TIMEOUT) ? WAIT_STATES : CALC_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] C_WAIT     = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(CALC_TIMEOUT - 1);
   localparam logic [SEL_W-1:0] C_DEF_SEL  = SEL_W'(DEFAULT_SRC);
   localparam logic [SEL_W-1:0] C_CALC_SEL = SEL_W'(CALC_SRC);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_XFER = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [AW-1:0]     r_mab_out;
   logic              r_mab_valid;
   logic              r_mab_rw;
   logic              r_mab_bw;
   logic              r_busy;
   logic              r_mab_done;
   logic              r_sel_err;
   logic              r_align_err;
   logic              r_timeout_err;
   logic              r_sel_acc;
   logic              r_align_acc;
   logic              r_timeout_acc;

   logic [AW-1:0]     w_src [NSRC];
   logic              w_sel_ok;
   logic [SEL_W-1:0]  w_eff_sel;
   logic              w_to_calc;
   logic              w_load_bw;
   logic [AW-1:0]     w_load_src;
   logic [AW-1:0]     w_load_addr;
   logic              w_misalign;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_src[gi] = bus.src_addr[gi*AW +: AW];
   end

   // One load path serves both the accept edge and the CALC resolution edge.
   always_comb begin
      w_sel_ok   = (32'(bus.sel) < 32'(NSRC));
      w_eff_sel  = w_sel_ok ? bus.sel : C_DEF_SEL;
      w_to_calc  = (w_eff_sel == C_CALC_SEL) && !bus.calc_done;
      w_load_bw  = bus.bw;
      w_load_src = w_src[w_eff_sel];
      if (r_state == ST_CALC) begin
         w_load_bw  = r_mab_bw;
         w_load_src = bus.calc_done ? w_src[CALC_SRC] : w_src[DEFAULT_SRC];
      end
      w_misalign  = !w_load_bw && w_load_src[0];
      w_load_addr = {w_load_src[AW-1:1], w_load_src[0] & w_load_bw};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_mab_out     <= '0;
         r_mab_valid   <= 1'b0;
         r_mab_rw      <= 1'b0;
         r_mab_bw      <= 1'b0;
         r_busy        <= 1'b0;
         r_mab_done    <= 1'b0;
         r_sel_err     <= 1'b0;
         r_align_err   <= 1'b0;
         r_timeout_err <= 1'b0;
         r_sel_acc     <= 1'b0;
         r_align_acc   <= 1'b0;
         r_timeout_acc <= 1'b0;
      end else begin
         r_mab_done    <= 1'b0;
         r_sel_err     <= 1'b0;
         r_align_err   <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req) begin
                  r_mab_rw      <= bus.rw;
                  r_mab_bw      <= bus.bw;
                  r_busy        <= 1'b1;
                  r_sel_acc     <= !w_sel_ok;
                  r_timeout_acc <= 1'b0;
                  if (w_to_calc) begin
                     r_state     <= ST_CALC;
                     r_cnt       <= '0;
                     r_align_acc <= 1'b0;
                  end else begin
                     r_state     <= ST_XFER;
                     r_cnt       <= C_WAIT;
                     r_mab_out   <= w_load_addr;
                     r_align_acc <= w_misalign;
                     r_mab_valid <= 1'b1;
                  end
               end
            end
            ST_CALC: begin
               if (bus.calc_done || (r_cnt == C_TMO_LAST)) begin
                  r_state       <= ST_XFER;
                  r_cnt         <= C_WAIT;
                  r_mab_out     <= w_load_addr;
                  r_align_acc   <= w_misalign;
                  r_timeout_acc <= !bus.calc_done;
                  r_mab_valid   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_XFER: begin
               if (r_cnt == '0) begin
                  r_state       <= ST_IDLE;
                  r_mab_valid   <= 1'b0;
                  r_busy        <= 1'b0;
                  r_mab_done    <= 1'b1;
                  r_sel_err     <= r_sel_acc;
                  r_align_err   <= r_align_acc;
                  r_timeout_err <= r_timeout_acc;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mab_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mab_out     = r_mab_out;
   assign bus.mab_valid   = r_mab_valid;
   assign bus.mab_rw      = r_mab_rw;
   assign bus.mab_bw      = r_mab_bw;
   assign bus.busy        = r_busy;
   assign bus.mab_done    = r_mab_done;
   assign bus.sel_err     = r_sel_err;
   assign bus.align_err   = r_align_err;
   assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_mab_sequencer.sv
`default_nettype none
// tb_mab_sequencer: three sequencer instances (WAIT_STATES 0/3/5) driven with
// directed and random transfers, checked against a per-cycle timeline model.
module tb_mab_sequencer;
   localparam int CT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req [3];
   logic [2:0]  sel [3];
   logic        rw [3];
   logic        bw [3];
   logic        calc_done [3];
   logic [79:0] src [3];
   logic [15:0] mout [3];
   logic        mval [3];
   logic        mrw [3];
   logic        mbw [3];
   logic        busy [3];
   logic        mdone [3];
   logic        serr [3];
   logic        aerr [3];
   logic        terr [3];

   int vectors     = 0;
   int miscompares = 0;
   logic [15:0] last_addr [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mab_sequencer_if #(.AW(16), .NSRC(5), .SEL_W(3)) bus ();
      assign bus.req       = req[gi];
      assign bus.sel       = sel[gi];
      assign bus.rw        = rw[gi];
      assign bus.bw        = bw[gi];
      assign bus.calc_done = calc_done[gi];
      assign bus.src_addr  = src[gi];
      assign mout[gi]      = bus.mab_out;
      assign mval[gi]      = bus.mab_valid;
      assign mrw[gi]       = bus.mab_rw;
      assign mbw[gi]       = bus.mab_bw;
      assign busy[gi]      = bus.busy;
      assign mdone[gi]     = bus.mab_done;
      assign serr[gi]      = bus.sel_err;
      assign aerr[gi]      = bus.align_err;
      assign terr[gi]      = bus.timeout_err;

      mab_sequencer #(
         .AW(16), .NSRC(5), .SEL_W(3), .DEFAULT_SRC(0), .CALC_SRC(2),
         .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 5)),
         .CALC_TIMEOUT(CT)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] mk_src(input logic [15:0] pc, sout, calc, sp, mdb);
      return {mdb, sp, calc, sout, pc};
   endfunction

   function automatic logic [31:0] all_outs(input int d);
      return {mout[d], mval[d], mrw[d], mbw[d], busy[d], mdone[d], serr[d], aerr[d], terr[d]};
   endfunction

   // cdel: edge offset where calc_done is first seen (0 = already at accept; > CT = never)
   task automatic txn(input int d, input logic [2:0] s, input logic r, input logic b,
                      input logic [79:0] sv, input int cdel);
      int ws, eff, idx, k, last;
      logic se, te, ae, in_calc, in_xfer, dn;
      logic [15:0] raw, addr, prev;
      ws  = (d == 0) ? 0 : ((d == 1) ? 3 : 5);
      se  = (s >= 3'd5);
      eff = se ? 0 : int'(s);
      te  = 1'b0;
      k   = 0;
      idx = eff;
      if (eff == 2 && cdel != 0) begin
         if (cdel <= CT) k = cdel;
         else begin
            k   = CT;
            idx = 0;
            te  = 1'b1;
         end
      end
      raw  = sv[idx*16 +: 16];
      ae   = !b && raw[0];
      addr = raw;
      if (!b) addr[0] = 1'b0;
      prev = last_addr[d];
      last = k + 2 + ws;

      req[d] = 1'b1; sel[d] = s; rw[d] = r; bw[d] = b; src[d] = sv;
      calc_done[d] = (eff == 2) ? (cdel == 0) : 1'($urandom);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         in_calc = (n <= k);
         in_xfer = (n > k) && (n <= k + 1 + ws);
         dn      = (n == last);
         chk($sformatf("d%0d n%0d valid", d, n), mval[d], in_xfer);
         chk($sformatf("d%0d n%0d busy", d, n), busy[d], !dn);
         chk($sformatf("d%0d n%0d done", d, n), mdone[d], dn);
         chk($sformatf("d%0d n%0d mab_out", d, n), mout[d], in_calc ? prev : addr);
         if (in_xfer) chk($sformatf("d%0d n%0d rw/bw", d, n), {mrw[d], mbw[d]}, {r, b});
         if (dn) chk($sformatf("d%0d flags", d), {serr[d], aerr[d], terr[d]}, {se, ae, te});
         if (n < last) begin
            req[d]       = 1'($urandom);
            sel[d]       = 3'($urandom);
            rw[d]        = 1'($urandom);
            bw[d]        = 1'($urandom);
            calc_done[d] = (eff == 2) ? (n >= cdel) : 1'($urandom);
         end else begin
            req[d]       = 1'b0;
            calc_done[d] = 1'b0;
         end
      end
      last_addr[d] = addr;
   endtask

   initial begin
      logic [95:0] rnd;
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; sel[i] = '0; rw[i] = 1'b0; bw[i] = 1'b0;
         calc_done[i] = 1'b0; src[i] = '0; last_addr[i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("d%0d reset outs", i), all_outs(i), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic PC fetch
      txn(0, 3'd0, 1'b1, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      @(negedge clk);
      // wait states with back-to-back accept in the done cycle
      txn(1, 3'd3, 1'b0, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      txn(1, 3'd0, 1'b1, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      // calc arrives three edges after accept, then calc timeout
      txn(0, 3'd2, 1'b1, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 3);
      @(negedge clk);
      txn(0, 3'd2, 1'b1, 1'b0, mk_src(16'hC000, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 99);
      // bad select, misaligned word, byte pass-through, calc ready at accept
      txn(0, 3'd7, 1'b0, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      txn(0, 3'd1, 1'b0, 1'b0, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      txn(0, 3'd1, 1'b0, 1'b1, mk_src(16'h4400, 16'h0201, 16'h1234, 16'h0A00, 16'h5555), 0);
      txn(2, 3'd2, 1'b1, 1'b0, mk_src(16'h4400, 16'h0201, 16'h2468, 16'h0A00, 16'h5555), 0);
      @(negedge clk);

      // asynchronous reset in the middle of a long XFER
      req[2] = 1'b1; sel[2] = 3'd4; rw[2] = 1'b1; bw[2] = 1'b0;
      src[2] = mk_src(16'h1110, 16'h0201, 16'h1234, 16'h0A00, 16'h7770);
      @(negedge clk);
      req[2] = 1'b0;
      chk("d2 pre-reset valid", mval[2], 1'b1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("d2 async reset outs", all_outs(2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) last_addr[i] = '0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk($sformatf("d2 post-reset n%0d done/valid", n), {mdone[2], mval[2], busy[2]}, 3'b000);
      end
      txn(2, 3'd4, 1'b1, 1'b1, mk_src(16'h1110, 16'h0201, 16'h1234, 16'h0A00, 16'h7771), 0);

      for (int it = 0; it < 60; it++) begin
         int d, gap;
         d   = int'($urandom_range(0, 2));
         rnd = {$urandom, $urandom, $urandom};
         txn(d, 3'($urandom), 1'($urandom), 1'($urandom), rnd[79:0], int'($urandom_range(0, 10)));
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mab_sequencer.md
# mab_sequencer

Parametrised memory-address-bus source sequencer: the next generation of the MAB source mux. Selects one of NSRC address sources (PC, Sout, CALC, SP, MDB, …) on a request/done handshake and registers it onto the MAB. It adds programmable wait states, a bounded wait for the address calculator, word-alignment enforcement and error reporting. It sits between the control unit (sel/req) and the memory interface (MAB, RW, BW).

## Interface

- AW, 16, address width
- NSRC, 5, number of address sources
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NSRC
- DEFAULT_SRC, 0, fallback source index (PC)
- CALC_SRC, 2, index of the source gated by calc_done
- WAIT_STATES, 0, extra cycles mab_valid is held (0..15)
- CALC_TIMEOUT, 8, maximum cycles spent waiting for calc_done (>=1)

Ports:

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  transfer request, sampled only in IDLE
- sel  in  SEL_W  source index, sampled with req
- rw  in  1  1 = read, sampled with req
- bw  in  1  1 = byte, 0 = word, sampled with req
- src_addr  in  NSRC*AW  packed sources; source i = bits [i*AW +: AW]
- calc_done  in  1  CALC_SRC address valid
- mab_out  out  AW  registered MAB address
- mab_valid  out  1  mab_out/mab_rw/mab_bw valid
- mab_rw, mab_bw  out  1 each  latched rw/bw
- busy  out  1  high in any state other than IDLE
- mab_done  out  1  one-cycle completion pulse
- sel_err, align_err, timeout_err  out  1 each  error flags, valid only while mab_done=1

## Operation

- States: IDLE, CALC, XFER.
- Reset value of every output is 0; state is IDLE; the wait counter is 0.
- IDLE, req=0: mab_out holds its last value. mab_valid, busy and all error flags are 0.
- IDLE, req=1: latch rw, bw and the effective select.
  - Effective select = sel if sel < NSRC. Otherwise it is DEFAULT_SRC, and sel_err is set.
  - Effective select = CALC_SRC with calc_done=0: go to CALC.
  - Otherwise: go to XFER and load mab_out from the effective source.
- CALC: busy=1, mab_valid=0, and the cycle counter increments each cycle.
  - calc_done=1: load src[CALC_SRC] on that edge and go to XFER.
  - Counter reaches CALC_TIMEOUT with calc_done still 0: load src[DEFAULT_SRC], set timeout_err, go to XFER.
- XFER: mab_valid=1 and busy=1. The wait counter is loaded with WAIT_STATES on entry.
  - Counter at 0: next state IDLE, with mab_done=1 for exactly one cycle.
  - Counter not 0: decrement.
- Alignment: on load with bw=0 and address bit 0 = 1, mab_out[0] is forced to 0 and align_err is set. Byte accesses pass bit 0 unchanged.
- Error flags: cleared on each accept and presented with mab_done. Multiple flags may be set together.
- req and sel changes after acceptance are ignored; an accepted transfer always completes.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no mab_done.

## Timing

- Accept edge = t (req=1 in IDLE).
- Direct source:
  - mab_valid is high for cycles t+1 .. t+1+WAIT_STATES.
  - mab_done is high in cycle t+2+WAIT_STATES; mab_valid is 0 in that cycle.
- CALC path, calc_done first seen at edge t+k (k>=1):
  - mab_valid from t+k+1.
  - mab_done at t+k+2+WAIT_STATES.
- Timeout: mab_out = DEFAULT_SRC from t+CALC_TIMEOUT+1, with timeout_err=1 at mab_done.
- The mab_done cycle is IDLE, so req there is accepted: back-to-back transfers start every WAIT_STATES+2 cycles.
- calc_done=1 at the accept edge itself takes the direct path (no CALC state).

## Test plan

- Defaults: PC=0x4400, req with sel=0, rw=1, bw=0 at t → mab_out=0x4400 and mab_valid=1 at t+1; mab_done pulse at t+2; no error flags.
- WAIT_STATES=3, SP=0x0A00 (sel=3): mab_valid high for exactly 4 cycles; mab_done at t+5; back-to-back req accepted at t+5 gives mab_valid at t+6.
- sel=2, calc_done raised 3 cycles after accept with CALC=0x1234: mab_valid=0 while in CALC; mab_out=0x1234 from t+4; mab_done at t+5.
- sel=2, calc_done held 0, CALC_TIMEOUT=8, PC=0xC000: mab_out=0xC000 at t+9; mab_done with timeout_err=1.
- sel=7 with Sout=0x0201, bw=0:
  - sel=7 → DEFAULT_SRC used.
  - Then sel=1, bw=0 → mab_out=0x0200 with align_err=1.
  - Same with bw=1 → mab_out=0x0201 and align_err=0.
  - sel=7 case reports sel_err=1.
- Reset asserted during XFER with WAIT_STATES=5: all outputs 0 asynchronously, state IDLE, no mab_done; the next req is accepted normally.
